// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key schedule and round datapath.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Round constants, indexed by round number 1..10
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (FIPS-197), shared by key expansion and SubBytes.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register file with a registered read port. AES_KEYEXP_ZEROIZE_EN adds a zeroize input.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
`ifdef AES_KEYEXP_ZEROIZE_EN
    input  logic       zeroize,
`endif
    input  aes_block_t key,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       keys_valid,
    input  logic [3:0] rk_idx,
    output aes_block_t rk_out
);

    localparam logic [3:0] LAST = 4'(NR);

    state_t     state, state_nxt;
    logic [3:0] rnd;
    logic [3:0] prev_idx;
    aes_block_t rk [0:NR];
    logic       ready_en;
    logic       zero_req;
    logic       load, step;

    aes_block_t prev, next_rk;
    aes_word_t  w0, w1, w2, w3, rot, sub, t;
    aes_word_t  n0, n1, n2, n3;
    logic [7:0] rcon_b;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign keys_valid = (state == DONE);

    // Round transform on the previous round key
    always_comb begin
        prev_idx = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
        prev     = rk[prev_idx];
        rcon_b   = (rnd >= 4'd1 && rnd <= LAST) ? RCON[rnd] : 8'h00;
        {w0, w1, w2, w3} = prev;
        rot = {w3[23:0], w3[31:24]};
    end

    for (genvar i = 0; i < NK; i++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    always_comb begin
        t       = sub ^ {rcon_b, 24'h0};
        n0      = w0 ^ t;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    // key_ready is held low until the first edge after reset releases
    always_ff @(posedge clk) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        key_ready = 1'b0;
        case (state)
            IDLE: begin
                key_ready = ready_en;
                if (key_valid && ready_en) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (rnd == LAST) state_nxt = DONE;
            end
            DONE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (zero_req) begin
            key_ready = 1'b0;
            load      = 1'b0;
            step      = 1'b0;
            state_nxt = IDLE;
        end
    end

    // Reads sample the pre-edge state, so an accept in DONE still returns the old key
    always_ff @(posedge clk) begin
        if (rst || zero_req) begin
            rnd    <= 4'd0;
            rk_out <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            if (load) begin
                rk[0] <= key;
                rnd   <= 4'd1;
            end else if (step) begin
                rk[rnd] <= next_rk;
                if (rnd != LAST) rnd <= rnd + 4'd1;
            end
            rk_out <= (keys_valid && rk_idx <= LAST) ? rk[rk_idx] : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed self-checking bench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;
    import aes_pkg::*;

    localparam aes_block_t FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_block_t FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam aes_block_t FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam aes_block_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam aes_block_t ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam aes_block_t ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic       clk = 1'b0;
    logic       rst;
    aes_block_t key;
    logic       key_valid;
    logic       key_ready;
    logic       keys_valid;
    logic [3:0] rk_idx;
    aes_block_t rk_out;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic       zeroize = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk        (clk),
        .rst        (rst),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key        (key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key = '0; key_valid = 1'b0; rk_idx = 4'd0;
        step(); step();
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", key_ready); end
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %b exp 0", keys_valid); end
        checks++; if (rk_out !== '0) begin errors++; $display("FAIL reset_rkout got %h exp 0", rk_out); end
        rst = 1'b0;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", key_ready); end
        step();
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b exp 1", key_ready); end
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            step();
            checks++; if (rk_out !== '0) begin errors++; $display("FAIL idle_read idx %0d got %h exp 0", i, rk_out); end
        end
    endtask

    task automatic test_fips();
        key = FIPS_KEY; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL expand_ready got %b exp 0", key_ready); end
        for (int i = 1; i < 10; i++) step();
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL kv_at_T9 got %b exp 0", keys_valid); end
        step();
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL kv_at_T10 got %b exp 1", keys_valid); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL done_ready got %b exp 1", key_ready); end
        rk_idx = 4'd0; step();
        checks++; if (rk_out !== FIPS_KEY) begin errors++; $display("FAIL fips_rk0 got %h exp %h", rk_out, FIPS_KEY); end
        rk_idx = 4'd1; step();
        checks++; if (rk_out !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1 got %h exp %h", rk_out, FIPS_RK1); end
        rk_idx = 4'd2; step();
        checks++; if (rk_out !== FIPS_RK2) begin errors++; $display("FAIL fips_rk2 got %h exp %h", rk_out, FIPS_RK2); end
        rk_idx = 4'd10; step();
        checks++; if (rk_out !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10 got %h exp %h", rk_out, FIPS_RK10); end
        for (int i = 11; i < 16; i++) begin
            rk_idx = 4'(i);
            step();
            checks++; if (rk_out !== '0) begin errors++; $display("FAIL done_oob idx %0d got %h exp 0", i, rk_out); end
        end
    endtask

    task automatic test_not_ready();
        key = FIPS_KEY; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rk_idx = 4'(i);
            step();
            checks++; if (rk_out !== '0) begin errors++; $display("FAIL expand_read idx %0d got %h exp 0", i, rk_out); end
        end
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL reexpand_kv got %b exp 1", keys_valid); end
        rk_idx = 4'd1; step();
        checks++; if (rk_out !== FIPS_RK1) begin errors++; $display("FAIL reexpand_rk1 got %h exp %h", rk_out, FIPS_RK1); end
    endtask

    task automatic test_reset_mid();
        key = '0; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 1; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL midrst_kv got %b exp 0", keys_valid); end
        rk_idx = 4'd0; step();
        checks++; if (rk_out !== '0) begin errors++; $display("FAIL midrst_rk0 got %h exp 0", rk_out); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", key_ready); end
        rk_idx = 4'd10; step();
        checks++; if (rk_out !== '0) begin errors++; $display("FAIL midrst_rk10 got %h exp 0", rk_out); end
        key = '0; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL zero_kv got %b exp 1", keys_valid); end
        rk_idx = 4'd1; step();
        checks++; if (rk_out !== ZERO_RK1) begin errors++; $display("FAIL zero_rk1 got %h exp %h", rk_out, ZERO_RK1); end
        rk_idx = 4'd10; step();
        checks++; if (rk_out !== ZERO_RK10) begin errors++; $display("FAIL zero_rk10 got %h exp %h", rk_out, ZERO_RK10); end
    endtask

    task automatic test_back_to_back();
        // Zero key is loaded; accept the FIPS key while reading its rk[10]
        key = FIPS_KEY; key_valid = 1'b1; rk_idx = 4'd10;
        step();
        checks++; if (rk_out !== ZERO_RK10) begin errors++; $display("FAIL b2b_old got %h exp %h", rk_out, ZERO_RK10); end
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL b2b_kv_fall got %b exp 0", keys_valid); end
        key = {4{32'hffffffff}};
        step();
        checks++; if (rk_out !== '0) begin errors++; $display("FAIL b2b_zero got %h exp 0", rk_out); end
        for (int i = 2; i < 10; i++) step();
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL b2b_kv_T9 got %b exp 0", keys_valid); end
        key_valid = 1'b0;
        step();
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL b2b_kv_T10 got %b exp 1", keys_valid); end
        step();
        checks++; if (rk_out !== FIPS_RK10) begin errors++; $display("FAIL b2b_new got %h exp %h", rk_out, FIPS_RK10); end
    endtask

`ifdef AES_KEYEXP_ZEROIZE_EN
    task automatic test_zeroize();
        key = '0; key_valid = 1'b1; zeroize = 1'b1; rk_idx = 4'd1;
        #1;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL zz_ready got %b exp 0", key_ready); end
        step();
        zeroize = 1'b0; key_valid = 1'b0;
        checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL zz_kv got %b exp 0", keys_valid); end
        checks++; if (rk_out !== '0) begin errors++; $display("FAIL zz_rkout got %h exp 0", rk_out); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL zz_idle got %b exp 1", key_ready); end
        step();
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL zz_not_accepted got %b exp 1", key_ready); end
        checks++; if (rk_out !== '0) begin errors++; $display("FAIL zz_read got %h exp 0", rk_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_not_ready();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_KEYEXP_ZEROIZE_EN
        test_zeroize();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
